// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic shift accumulator.
package da_pkg;

  localparam int DA_DATA_W = 16;
  localparam int DA_LUT_W  = 20;
  localparam int DA_ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } da_acc_state_t;

  // Sign-extend a LUT partial sum to accumulator width.
  function automatic logic [DA_ACC_W-1:0] da_sext(input logic [DA_LUT_W-1:0] v);
    return {{(DA_ACC_W-DA_LUT_W){v[DA_LUT_W-1]}}, v};
  endfunction

endpackage

// File: rtl/da_bit_counter.sv
// Down-counter selecting the current sample bit; rests at N-1 and reloads
// there on load, so the next pass always begins at the sign bit.
module da_bit_counter #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Reload to the MSB position on reset/load, otherwise count down when enabled.
  always_ff @(posedge clk) begin
    if (rst || load_i) cnt_q <= W'(N-1);
    else if (en_i)     cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/da_shift_accumulator.sv
// Bit-serial, MSB-first scale accumulator for the DA FIR datapath.
// Optional overflow reporting is enabled by defining DA_ACC_OVF_EN.
module da_shift_accumulator
  import da_pkg::*;
#(
  parameter  int DATA_W = DA_DATA_W,
  parameter  int LUT_W  = DA_LUT_W,
  parameter  int ACC_W  = DA_ACC_W,
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LUT_W-1:0] lut_data,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid
`ifdef DA_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  da_acc_state_t    state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] lut_ext, shifted, added, negated;
  logic             sign_step, last_bit, in_accum;

  assign in_accum  = (state_q == ACCUM);
  assign sign_step = (bit_idx == IDX_W'(DATA_W-1));
  assign lut_ext   = da_sext(lut_data);
  assign shifted   = acc_q << 1;
  assign added     = shifted + lut_ext;
  assign negated   = '0 - lut_ext;

  // Bit index walks DATA_W-1 down to 0 while accumulating, then reloads.
  da_bit_counter #(.N(DATA_W)) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (in_accum && last_bit),
    .en_i   (in_accum),
    .cnt_o  (bit_idx),
    .tc_o   (last_bit)
  );

  // Sign bit carries negative weight, so it restarts the sum as its negation.
  always_comb begin
    acc_d = added;
    if (sign_step) acc_d = negated;
  end

`ifdef DA_ACC_OVF_EN
  logic flag_q, flag_d;
  logic sub_ovf, shift_ovf, add_ovf;

  // 0 - L overflows only when L is the most negative value.
  assign sub_ovf   = lut_ext[ACC_W-1] & negated[ACC_W-1];
  // Doubling is lossy whenever the top two bits disagree.
  assign shift_ovf = acc_q[ACC_W-1] ^ acc_q[ACC_W-2];
  assign add_ovf   = (shifted[ACC_W-1] == lut_ext[ACC_W-1]) &&
                     (added[ACC_W-1]   != shifted[ACC_W-1]);

  // Sticky flag restarts on the sign-bit step of each pass.
  always_comb begin
    flag_d = flag_q | shift_ovf | add_ovf;
    if (sign_step) flag_d = sub_ovf;
  end

  // Overflow flag register, updated only while accumulating.
  always_ff @(posedge clk) begin
    if (rst)           flag_q <= 1'b0;
    else if (in_accum) flag_q <= flag_d;
  end

  assign ovf = (state_q == DONE) & flag_q;
`endif

  // Control FSM and accumulator; start is only honoured in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_q <= ACCUM;
        ACCUM: begin
          acc_q <= acc_d;
          if (last_bit) state_q <= DONE;
        end
        DONE:    state_q <= start ? ACCUM : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = in_accum;
  assign sum_valid = (state_q == DONE);
  assign sum_out   = acc_q;

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Randomized self-checking bench for da_shift_accumulator.
// Reference: result = -L[15]*2^15 + sum_{i<15} L[i]*2^i, mod 2^32.
module tb_da_shift_accumulator;

  localparam int DW = 16;
  localparam int LW = 20;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] lut_data;
  logic [3:0]    bit_idx;
  logic          busy;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
`ifdef DA_ACC_OVF_EN
  logic          ovf;
`endif

  logic signed [LW-1:0] lut_tbl [DW];
  int checks = 0;
  int passed = 0;

  da_shift_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lut_data  (lut_data),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .sum_out   (sum_out),
    .sum_valid (sum_valid)
`ifdef DA_ACC_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // LUT model: combinational lookup by bit index.
  always_comb lut_data = lut_tbl[bit_idx];

  // Exact-integer reference: weighted bit sum, plus whether any exact
  // intermediate value left the signed 32-bit range.
  function automatic void model(output logic [31:0] s, output bit ov);
    longint ex;
    ov = 0;
    ex = -longint'(lut_tbl[DW-1]);
    for (int i = DW-2; i >= 0; i--) begin
      ex = ex * 2;
      if (ex > 64'sd2147483647 || ex < -64'sd2147483648) ov = 1;
      ex = ex + longint'(lut_tbl[i]);
      if (ex > 64'sd2147483647 || ex < -64'sd2147483648) ov = 1;
    end
    s = ex[31:0];
  endfunction

  function automatic void fill_rand();
    for (int i = 0; i < DW; i++) lut_tbl[i] = LW'($urandom);
  endfunction

  function automatic void fill_const(input int v);
    for (int i = 0; i < DW; i++) lut_tbl[i] = LW'(v);
  endfunction

  // One start pulse from a negedge; waits (bounded) for sum_valid.
  task automatic run_txn(output logic [31:0] s, output int lat, output int nbusy,
                         output logic o, output bit got);
    start = 1'b1; got = 0; lat = 0; nbusy = 0; o = 1'b0; s = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (sum_valid) begin
        got = 1; lat = c; s = sum_out;
`ifdef DA_ACC_OVF_EN
        o = ovf;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; fill_const(0);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 32'h0 || bit_idx !== 4'd15)
      $display("FAIL reset: busy=%b valid=%b sum=%h idx=%0d, need 0 0 00000000 15",
               busy, sum_valid, sum_out, bit_idx);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    logic [31:0] s; int lat, nb; logic o; bit got;
    fill_const(1);
    run_txn(s, lat, nb, o, got);
    checks++;
    if (!got || s !== 32'hFFFFFFFF) $display("FAIL ones_sum: got=%0d sum=%h need FFFFFFFF", got, s);
    else passed++;
    checks++;
    if (lat !== 17) $display("FAIL ones_latency: %0d need 17", lat); else passed++;
    checks++;
    if (nb !== 16) $display("FAIL ones_busy_cycles: %0d need 16", nb); else passed++;
`ifdef DA_ACC_OVF_EN
    checks++;
    if (o !== 1'b0) $display("FAIL ones_ovf: %b need 0", o); else passed++;
`endif
  endtask

  task automatic test_directed();
    logic [31:0] s; int lat, nb; logic o; bit got;
    fill_const(0); lut_tbl[15] = 20'sd5;
    run_txn(s, lat, nb, o, got);
    checks++;
    if (!got || s !== 32'hFFFD8000) $display("FAIL sign_bit_only: %h need FFFD8000", s);
    else passed++;
    fill_const(0); lut_tbl[0] = 20'sd3;
    run_txn(s, lat, nb, o, got);
    checks++;
    if (!got || s !== 32'd3) $display("FAIL lsb_only: %h need 00000003", s); else passed++;
    fill_const(1); lut_tbl[15] = 20'sd0;
    run_txn(s, lat, nb, o, got);
    checks++;
    if (!got || s !== 32'd32767) $display("FAIL max_pos: %0d need 32767", s); else passed++;
  endtask

  task automatic test_back_to_back();
    int vc[$]; logic [31:0] vs[$]; int idle;
    fill_const(1); lut_tbl[15] = 20'sd0;
    idle = 0; start = 1'b1;
    for (int c = 1; c <= 60 && vc.size() < 2; c++) begin
      @(negedge clk);
      if (sum_valid) begin vc.push_back(c); vs.push_back(sum_out); end
      else if (!busy && vc.size() == 1) idle++;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (vc.size() != 2) $display("FAIL b2b_pulses: %0d need 2", vc.size());
    else begin
      passed++;
      checks++;
      if (vc[1] - vc[0] != 17) $display("FAIL b2b_spacing: %0d need 17", vc[1] - vc[0]);
      else passed++;
      checks++;
      if (vs[0] !== 32'd32767 || vs[1] !== 32'd32767)
        $display("FAIL b2b_sums: %0d %0d need 32767", vs[0], vs[1]);
      else passed++;
    end
    checks++;
    if (idle != 0) $display("FAIL b2b_idle_bubble: %0d need 0", idle); else passed++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] s, es; int lat, nb, nv; logic o; bit got, eo, hit;
    fill_rand();
    start = 1'b1; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bit_idx == 4'd7 && busy) hit = 1;
    end
    checks++;
    if (!hit) $display("FAIL mid_reset_reach_bit7: timeout, need bit_idx 7"); else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 32'h0 || bit_idx !== 4'd15)
      $display("FAIL mid_reset_state: busy=%b valid=%b sum=%h idx=%0d need 0 0 0 15",
               busy, sum_valid, sum_out, bit_idx);
    else passed++;
    rst = 1'b0; nv = 0;
    repeat (20) begin @(negedge clk); if (sum_valid) nv++; end
    checks++;
    if (nv != 0) $display("FAIL mid_reset_no_valid: %0d pulses need 0", nv); else passed++;
    model(es, eo);
    run_txn(s, lat, nb, o, got);
    checks++;
    if (!got || s !== es) $display("FAIL post_reset_sum: %h need %h", s, es); else passed++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] s, es; int nv; bit eo;
    fill_rand(); model(es, eo);
    nv = 0; s = '0; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (sum_valid) begin nv++; s = sum_out; end
    end
    checks++;
    if (nv != 1) $display("FAIL start_in_accum_pulses: %0d need 1", nv); else passed++;
    checks++;
    if (s !== es) $display("FAIL start_in_accum_sum: %h need %h", s, es); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] s, es; int lat, nb; logic o; bit got, eo;
    for (int n = 0; n < 20; n++) begin
      fill_rand();
      if (n < 5) for (int i = 0; i < DW; i++) lut_tbl[i] = lut_tbl[i] >>> 12;
      model(es, eo);
      run_txn(s, lat, nb, o, got);
      checks++;
      if (!got || s !== es || lat != 17)
        $display("FAIL random_%0d: got=%0d sum=%h lat=%0d need sum=%h lat=17", n, got, s, lat, es);
      else passed++;
`ifdef DA_ACC_OVF_EN
      checks++;
      if (o !== logic'(eo)) $display("FAIL random_ovf_%0d: %b need %b", n, o, eo); else passed++;
`endif
    end
  endtask

`ifdef DA_ACC_OVF_EN
  task automatic test_ovf();
    logic [31:0] s; int lat, nb; logic o; bit got;
    fill_const(0); lut_tbl[15] = -20'sd524288;
    run_txn(s, lat, nb, o, got);
    checks++;
    if (!got || s !== 32'h0 || o !== 1'b1) $display("FAIL ovf_wrap: sum=%h ovf=%b need 0 1", s, o);
    else passed++;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_outside_valid: %b need 0", ovf); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_ones();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_start_ignored();
    test_random();
`ifdef DA_ACC_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
